// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter slice.
// port_e names the requester that owns the memory port in a given cycle.
package mem_pkg;

   typedef enum logic [1:0] {
      PORT_NONE,
      PORT_DBG,
      PORT_IF,
      PORT_LS
   } port_e;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF  = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request always wins, and a tie goes
// to whichever side did not win most recently.
module rr_pick2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   // last_win = 0 means req[0] won most recently, so a tie goes to req[1]
   logic last_win;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_win ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_win <= 1'b0;
      else if (update && (gnt != 2'b00))
         last_win <= gnt[1];
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between debug, fetch and load/store.
// Debug has absolute priority; fetch and load/store alternate on conflicts.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   output logic                  dbg_gnt,
   output logic                  if_gnt,
   output logic                  ls_gnt,
   output logic                  dbg_rvalid,
   output logic                  if_rvalid,
   output logic                  ls_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic [DATA_WIDTH-1:0] ls_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   logic [1:0] rr_req;
   logic [1:0] rr_gnt;
   logic       rr_update;
   port_e      winner;
   port_e      resp_port;
   logic       denied;

   // The picker only sees fetch/load-store when debug is idle and reset is low,
   // so its history advances only on real fetch/load-store grants.
   assign rr_req    = {ls_req, if_req} & {2{~rst & ~dbg_req}};
   assign rr_update = ~rst & ~dbg_req;

   rr_pick2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    (rr_req),
      .update (rr_update),
      .gnt    (rr_gnt)
   );

   assign dbg_gnt = dbg_req & ~rst;
   assign if_gnt  = rr_gnt[0];
   assign ls_gnt  = rr_gnt[1];

   always_comb begin
      winner    = PORT_NONE;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dbg_gnt) begin
         winner    = PORT_DBG;
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (if_gnt) begin
         winner    = PORT_IF;
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end else if (ls_gnt) begin
         winner    = PORT_LS;
         mem_en    = 1'b1;
         mem_we    = ls_we;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
      end
   end

   // Remembers who owns the memory response arriving next cycle
   always_ff @(posedge clk) begin
      if (rst)
         resp_port <= PORT_NONE;
      else
         resp_port <= winner;
   end

   assign dbg_rvalid = (resp_port == PORT_DBG);
   assign if_rvalid  = (resp_port == PORT_IF);
   assign ls_rvalid  = (resp_port == PORT_LS);
   assign dbg_rdata  = mem_rdata;
   assign if_rdata   = mem_rdata;
   assign ls_rdata   = mem_rdata;

   assign denied = (dbg_req & ~dbg_gnt) | (if_req & ~if_gnt) | (ls_req & ~ls_gnt);

   // Counts conflict cycles, not denied requests, and sticks at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         stall_count <= '0;
      else if (denied && (stall_count != '1))
         stall_count <= stall_count + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model and a
// narrow-counter second instance for saturation.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        dbg_req, dbg_we, if_req, ls_req, ls_we;
   logic [15:0] dbg_addr, if_addr, ls_addr;
   logic [31:0] dbg_wdata, ls_wdata;
   logic        dbg_gnt, if_gnt, ls_gnt;
   logic        dbg_rvalid, if_rvalid, ls_rvalid;
   logic [31:0] dbg_rdata, if_rdata, ls_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic [15:0] stall_count;

   logic        s_dbg_gnt, s_if_gnt, s_ls_gnt;
   logic        s_dbg_rvalid, s_if_rvalid, s_ls_rvalid;
   logic [31:0] s_dbg_rdata, s_if_rdata, s_ls_rdata;
   logic        s_mem_en, s_mem_we;
   logic [15:0] s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [3:0]  s_stall_count;

   logic [31:0] mem [0:255];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .if_req(if_req), .if_addr(if_addr),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .dbg_gnt(dbg_gnt), .if_gnt(if_gnt), .ls_gnt(ls_gnt),
      .dbg_rvalid(dbg_rvalid), .if_rvalid(if_rvalid), .ls_rvalid(ls_rvalid),
      .dbg_rdata(dbg_rdata), .if_rdata(if_rdata), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_count(stall_count)
   );

   mem_arbiter #(.CNT_WIDTH(4)) dut_small (
      .clk(clk), .rst(rst),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .if_req(if_req), .if_addr(if_addr),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .dbg_gnt(s_dbg_gnt), .if_gnt(s_if_gnt), .ls_gnt(s_ls_gnt),
      .dbg_rvalid(s_dbg_rvalid), .if_rvalid(s_if_rvalid), .ls_rvalid(s_ls_rvalid),
      .dbg_rdata(s_dbg_rdata), .if_rdata(s_if_rdata), .ls_rdata(s_ls_rdata),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(32'h0), .stall_count(s_stall_count)
   );

   // Read-first single-port memory with one cycle of read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            mem[mem_addr[7:0]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   typedef struct {
      logic        dbg;
      logic        ifr;
      logic        ls;
      logic [2:0]  gnt;
      logic [2:0]  rv;
      logic [15:0] stall;
   } vec_t;

   vec_t vecs [14];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic d, input logic i,
                                input logic l, input logic lwe);
      rst     = r;
      dbg_req = d;
      if_req  = i;
      ls_req  = l;
      ls_we   = lwe;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_addr;

      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      dbg_we = 1'b0; dbg_addr = 16'h0033; dbg_wdata = 32'hD0D0D0D0;
      if_addr = 16'h0011; ls_addr = 16'h0022; ls_wdata = 32'h0;

      // Table: fetch/load-store ties, debug override, single requesters
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 3'b001, 3'b000, 16'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'b010, 3'b001, 16'd1};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'b001, 3'b010, 16'd2};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'b010, 3'b001, 16'd3};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 16'd4};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b100, 3'b000, 16'd4};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 16'd5};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 16'd6};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'b010, 3'b100, 16'd7};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'b001, 3'b010, 16'd7};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 3'b010, 3'b001, 16'd7};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b100, 3'b010, 16'd8};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 3'b001, 3'b100, 16'd9};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 16'd10};

      // Reset with every request raised: nothing may be granted
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();
      #3;
      checkOutput("rst_gnts", {dbg_gnt, if_gnt, ls_gnt}, 3'b000);
      checkOutput("rst_mem_en", mem_en, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      checkOutput("post_rst_rvalid", {dbg_rvalid, if_rvalid, ls_rvalid}, 3'b000);
      checkOutput("post_rst_stall", stall_count, 16'd0);
      nextCycle();

      // Single fetch read
      mem[8'h10] = 32'hDEADBEEF;
      if_addr = 16'h0010;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #3;
      checkOutput("if_gnt", if_gnt, 1'b1);
      checkOutput("if_mem_addr", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0010});
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      checkOutput("if_rvalid", {dbg_rvalid, if_rvalid, ls_rvalid}, 3'b010);
      checkOutput("if_rdata", if_rdata, 32'hDEADBEEF);
      nextCycle();

      // Load/store write then immediate read-back, back to back
      ls_addr = 16'h0020; ls_wdata = 32'h12345678;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      #3;
      checkOutput("ls_wr_gnt", ls_gnt, 1'b1);
      checkOutput("ls_wr_mem", {mem_en, mem_we, mem_addr}, {2'b11, 16'h0020});
      checkOutput("ls_wr_wdata", mem_wdata, 32'h12345678);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      checkOutput("ls_rd_gnt", {ls_gnt, mem_we}, 2'b10);
      checkOutput("ls_wr_ack", ls_rvalid, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      checkOutput("ls_rd_rvalid", ls_rvalid, 1'b1);
      checkOutput("ls_rd_rdata", ls_rdata, 32'h12345678);
      checkOutput("dbg_rdata_fanout", dbg_rdata, 32'h12345678);
      nextCycle();

      // Reset arriving the cycle after a read grant
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      checkOutput("pre_rst_ls_gnt", ls_gnt, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      checkOutput("midrst_gnt", {ls_gnt, mem_en}, 2'b00);
      checkOutput("midrst_rvalid", ls_rvalid, 1'b1);
      checkOutput("midrst_rdata", ls_rdata, 32'h12345678);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      checkOutput("after_rst_rvalid", {dbg_rvalid, if_rvalid, ls_rvalid}, 3'b000);
      checkOutput("after_rst_stall", stall_count, 16'd0);
      nextCycle();

      // Table-driven arbitration sequence
      if_addr = 16'h0011; ls_addr = 16'h0022;
      for (int v = 0; v < 14; v++) begin
         applyStimulus(1'b0, vecs[v].dbg, vecs[v].ifr, vecs[v].ls, 1'b0);
         exp_addr = vecs[v].gnt[2] ? 16'h0033 : vecs[v].gnt[1] ? 16'h0011 :
                    vecs[v].gnt[0] ? 16'h0022 : 16'h0000;
         #3;
         checkOutput($sformatf("vec%0d_gnt", v), {dbg_gnt, if_gnt, ls_gnt}, vecs[v].gnt);
         checkOutput($sformatf("vec%0d_rvalid", v), {dbg_rvalid, if_rvalid, ls_rvalid}, vecs[v].rv);
         checkOutput($sformatf("vec%0d_stall", v), stall_count, vecs[v].stall);
         checkOutput($sformatf("vec%0d_mem", v), {mem_en, mem_addr},
                     {(vecs[v].gnt != 3'b000), exp_addr});
         nextCycle();
      end

      // Saturation of the 4-bit counter against the 16-bit one
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 20; c++) begin
         #3;
         if (c == 14) begin
            checkOutput("sat_mid_small", s_stall_count, 4'd14);
            checkOutput("sat_mid_big", stall_count, 16'd14);
         end
         nextCycle();
      end
      #3;
      checkOutput("sat_small", s_stall_count, 4'hF);
      checkOutput("sat_big", stall_count, 16'd20);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single-port synchronous memory among three requesters: instruction fetch (if), load/store (ls) and a debug/preload port (dbg). Each cycle it grants at most one request, drives the memory port, and routes the one-cycle-latency read data back to the granted requester. It sits between the CPU core and `memory`. Its stall counter gives the bench a view of structural conflicts.

## Interface
- ADDR_WIDTH, 16, word address width
- DATA_WIDTH, 32, data word width
- CNT_WIDTH, 16, stall counter width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- dbg_req / if_req / ls_req  in  1  request valid, held with fields stable until granted
- dbg_we / ls_we  in  1  write enable (if port is read-only)
- dbg_addr / if_addr / ls_addr  in  ADDR_WIDTH  word address
- dbg_wdata / ls_wdata  in  DATA_WIDTH  write data
- dbg_gnt / if_gnt / ls_gnt  out  1  request accepted this cycle
- dbg_rvalid / if_rvalid / ls_rvalid  out  1  response pulse, one cycle after grant
- dbg_rdata / if_rdata / ls_rdata  out  DATA_WIDTH  read data, valid with rvalid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, one cycle after mem_en
- stall_count  out  CNT_WIDTH  saturating count of cycles with at least one denied request

## Operation
- Grants are combinational from the current reqs and registered priority state. Exactly one gnt is high when any req is high and rst=0.
- Priority: dbg is fixed highest. if and ls use 2-way round-robin. On an if/ls tie, the grant goes to the port not granted most recently among the two. A single requester always wins.
- last_rr register updates only when if or ls is granted. Reset value = IF, so the first tie after reset goes to ls.
- In the grant cycle, mem_en=1 and mem_we/addr/wdata are muxed from the winner. The if port forces mem_we=0. With no grant, mem_en=0 and the other memory outputs are don't-care but driven to 0.
- resp_port register (NONE/DBG/IF/LS) captures the winner each cycle. Next cycle, the matching rvalid pulses and all rdata outputs carry mem_rdata. rvalid also pulses for writes as an ack, with rdata don't-care.
- Back-to-back grants every cycle are allowed; there is no bubble.
- stall_count increments when any req is high without its gnt. It saturates at all-ones.

## Timing
- Reset (rst=1 at an edge): resp_port=NONE, last_rr=IF, stall_count=0.
- While rst=1, all gnt=0 and mem_en=0 combinationally. The cycle after reset deasserts, all rvalid=0.
- Latency: request to gnt is 0 cycles if it wins. gnt to rvalid is exactly 1 cycle.
- Reset mid-operation: a grant issued in the cycle before rst rises still gets its rvalid, because resp_port is sampled at that edge. Any grant request coinciding with rst is suppressed.
- Requesters must hold req and fields until gnt. Dropping req before gnt is legal and simply withdraws the request.
- dbg held continuously starves if and ls; this is intended for preload. stall_count counts those cycles.

## Structure
- mem_pkg: `port_e` enum {PORT_NONE, PORT_DBG, PORT_IF, PORT_LS} and default width localparams.
- Sub-module rr_pick2: 2-input round-robin picker with a last-winner register, an update enable, and one-hot grant out.
- Top level holds the dbg override, the memory mux, the resp_port register, the rdata fan-out and the stall counter.

## Test plan
- Reset, then if_req to addr 0x0010 with memory holding 0xDEADBEEF -> if_gnt in the same cycle, then if_rvalid=1 and if_rdata=0xDEADBEEF next cycle. No other rvalid.
- ls write 0x12345678 to 0x0020, then ls read of 0x0020 on the next cycle -> two consecutive ls_gnt, ls_rvalid on both following cycles, second rdata=0x12345678.
- if_req and ls_req both held for 4 cycles right after reset -> grant order ls, if, ls, if. stall_count=4.
- dbg_req held 3 cycles alongside if_req -> dbg granted 3 times, then if. stall_count increments 3.
- rst asserted in the cycle after an ls read grant -> ls_rvalid still pulses. The grant in the rst cycle is suppressed, and all outputs are at reset values afterwards.
- With CNT_WIDTH=4, hold a conflict for 20 cycles -> stall_count saturates at 0xF.
